// File: rtl/fifo_pkg.sv
// Shared sizing helpers, default geometry and the status bundle for param_fifo.
// Used by both builds; PARAM_FIFO_FWFT_EN does not change anything here.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 10;

  // Count must represent 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } status_t;

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer-facing bundle of param_fifo. Handshake: push/pop are requests
// sampled on the rising edge; acceptance is decided from the registered count only.
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  import fifo_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, data_in, pop,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, push, data_in, pop,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage for param_fifo: registered read with read-before-write,
// or asynchronous read when PARAM_FIFO_FWFT_EN is defined.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

`ifdef PARAM_FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = rst_n ^ re;
  assign rdata     = mem_q[raddr];
`else
  // Non-blocking read of mem_q returns the old word when raddr == waddr.
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold and sticky flags.
// Define PARAM_FIFO_FWFT_EN for first-word fall-through reads.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic        clk,
  input  logic        reset,
  param_fifo_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = ptr_w(DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             pop_ok, push_ok, we, re;
  logic [WIDTH-1:0] rdata;
  status_t          st;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // Flags come from registered state only; no path from push/pop.
  assign st = '{
    full:         (count_q == CNT_FULL),
    empty:        (count_q == '0),
    almost_full:  (count_q >= CNT_AF),
    almost_empty: (count_q <= CNT_AE),
    overflow:     ovf_q,
    underflow:    unf_q
  };

  always_comb begin
    pop_ok   = bus.pop & ~st.empty;
    push_ok  = bus.push & (~st.full | pop_ok);
    we       = push_ok & ~bus.flush;
    re       = pop_ok & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (we) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (re) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({we, re})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (bus.push & ~push_ok);
      unf_d = unf_q | (bus.pop & ~pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

`ifdef PARAM_FIFO_FWFT_EN
  assign bus.data_out = st.empty ? '0 : rdata;
  assign bus.rd_valid = ~st.empty;
`else
  logic rd_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid_q <= 1'b0;
    else        rd_valid_q <= re;
  end

  assign bus.data_out = rdata;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the 8-bit/10-deep byte FIFO.
- Generalises data width and depth; depth need not be a power of two.
- Adds:
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - defined simultaneous push/pop at every fill level
  - sticky overflow/underflow flags
  - synchronous flush
  - read-valid strobe
- Sits between byte/word producers and consumers (UART, SPI, LED/video paths) on the ECP5 fabric.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 10, number of storage entries (>=2, any integer).
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (assert 0 clears all state immediately; deassertion used synchronously).
- flush  in  1  synchronous clear of contents and sticky flags.
- push  in  1  write request.
- data_in  in  WIDTH  write data, sampled on accepted push.
- pop  in  1  read request.
- data_out  out  WIDTH  read data.
- rd_valid  out  1  data_out holds freshly popped word (default mode).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.

Behaviour:
- Reset (reset=0, async) clears:
  - wr_ptr, rd_ptr, count to 0
  - data_out to 0, rd_valid to 0
  - overflow and underflow to 0
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0? n/a) 0.
  - Memory contents are not cleared.
- flush=1 at a clock edge: same effect as reset except data_out holds its value. flush has priority over push/pop in that cycle, and both are ignored.
- Acceptance:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
- Pointers: each pointer increments by 1 on its accepted operation and wraps from DEPTH-1 to 0 (explicit compare, no modulo of a power of two).
- count update:
  - +1 on push_ok only
  - -1 on pop_ok only
  - unchanged when both or neither.
- Status flags (full/empty/almost_*) are decoded from the count register only; no combinational path from push/pop.
- Simultaneous push & pop:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: both accepted; the read returns the old head word (read-before-write when pointers coincide); count stays DEPTH.
  - Empty: push accepted, pop rejected, underflow set; count becomes 1.
- Rejected operations:
  - push while full with no pop_ok: data dropped, overflow set.
  - pop while empty: data_out unchanged, rd_valid=0, underflow set.
  - Sticky flags clear only on reset or flush.
- Read timing (default mode): on pop_ok, data_out <= mem[rd_ptr] at that edge, so data is valid one cycle after the pop request. rd_valid=1 for exactly that cycle, else 0. data_out holds its value between pops.

Optional Feature:
- Macro: PARAM_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever ~empty; 0 when empty.
  - pop acknowledges the displayed word; the next word appears after the edge.
  - rd_valid = ~empty.
  - Zero-latency read.
- Undefined: registered read as in Behaviour, latency 1.
- All other behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg:
  - function for counter width: clog2(DEPTH+1)
  - pointer width: clog2(DEPTH)
  - localparams for default WIDTH/DEPTH
  - typedef for status bundle {full, empty, almost_full, almost_empty, overflow, underflow}
- Sub-module fifo_mem:
  - simple dual-port RAM, WIDTH x DEPTH, one write port, one read port
  - synchronous read, or async read under PARAM_FIFO_FWFT_EN
  - read-before-write on address collision
  - infers ECP5 EBR/distributed RAM
- param_fifo contains pointers, count, flags.

Test Plan (WIDTH=8, DEPTH=10, AF=8, AE=2):
- Reset then push 0x01..0x0A over 10 cycles:
  - count=10, full=1, almost_full from count 8, almost_empty drops at count 3.
  - 11th push 0xFF -> overflow=1, count stays 10.
- From full, pop 10 times:
  - data_out sequence 0x01..0x0A, each one cycle after pop with rd_valid pulses.
  - then empty=1.
  - 11th pop -> underflow=1, data_out stays 0x0A.
- Wrap-around: push/pop 25 words with occupancy held at 3 -> output order preserved across pointer wrap at 9->0; count constant 3.
- Simultaneous push 0xAA + pop:
  - when full: count stays 10, popped word = old head, 0xAA read 10 pops later.
  - when empty: count becomes 1, underflow=1.
- Assert reset low asynchronously mid-stream with count=5 (between edges) -> count=0, empty=1, data_out=0, sticky flags 0 immediately.
- flush with push=1 same cycle -> count=0, push ignored.
- FWFT build (PARAM_FIFO_FWFT_EN): push 0x5C into empty -> data_out=0x5C and rd_valid=1 the cycle after push with no pop issued.
